// File: rtl/start_accept_pkg.sv
// Shared types and default sizing for the start/accept transaction tracker.
package start_accept_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam int DEF_LAT_W   = 8;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr beats load beats inc.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         inc,
    output logic [W-1:0] value
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (load) begin
            value <= W'(1);
        end else if (inc && (value != '1)) begin
            value <= value + W'(1);
        end
    end

endmodule

// File: rtl/start_accept_tracker.sv
// Follows one start/cancel/accept transaction at a time and turns it into
// latency, completion/abort pulses, saturating event counts and sticky errors.
module start_accept_tracker
    import start_accept_pkg::*;
#(
    parameter int LAT_W   = DEF_LAT_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cancel,
    input  logic             accept,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             timed_out,
    output logic [LAT_W-1:0] latency,
    output logic [CNT_W-1:0] done_count,
    output logic [CNT_W-1:0] abort_count,
    output logic             err_spurious_accept,
    output logic             err_restart
);

    localparam logic [31:0] TIMEOUT_U = TIMEOUT;

    state_e           state, state_nx;
    logic [LAT_W-1:0] lat_cnt;
    logic             lat_clr, lat_load, lat_inc;
    logic             done_nx, aborted_nx, timed_out_nx;
    logic             spur_set, restart_set;
    logic             to_hit;

    // ">=" rather than "==" so a restart-only cycle landing on the limit
    // still times out one cycle later instead of running on forever.
    assign to_hit = (TIMEOUT != 0) && (32'(lat_cnt) >= TIMEOUT_U);

    always_comb begin
        state_nx     = state;
        lat_clr      = 1'b0;
        lat_load     = 1'b0;
        lat_inc      = 1'b0;
        done_nx      = 1'b0;
        aborted_nx   = 1'b0;
        timed_out_nx = 1'b0;
        spur_set     = 1'b0;
        restart_set  = 1'b0;
        case (state)
            IDLE: begin
                spur_set = accept;
                if (start && cancel) begin
                    aborted_nx = 1'b1;
                end else if (start) begin
                    state_nx = WAIT;
                    lat_load = 1'b1;
                end
            end
            WAIT: begin
                if (cancel) begin
                    state_nx   = IDLE;
                    lat_clr    = 1'b1;
                    aborted_nx = 1'b1;
                end else if (accept) begin
                    done_nx = 1'b1;
                    if (start) begin
                        lat_load = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        lat_clr  = 1'b1;
                    end
                end else if (start) begin
                    restart_set = 1'b1;
                    lat_inc     = 1'b1;
                end else if (to_hit) begin
                    state_nx     = IDLE;
                    lat_clr      = 1'b1;
                    aborted_nx   = 1'b1;
                    timed_out_nx = 1'b1;
                end else begin
                    lat_inc = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            done                <= 1'b0;
            aborted             <= 1'b0;
            timed_out           <= 1'b0;
            latency             <= '0;
            err_spurious_accept <= 1'b0;
            err_restart         <= 1'b0;
        end else begin
            state     <= state_nx;
            done      <= done_nx;
            aborted   <= aborted_nx;
            timed_out <= timed_out_nx;
            if (done_nx) begin
                latency <= lat_cnt;
            end
            if (spur_set) begin
                err_spurious_accept <= 1'b1;
            end
            if (restart_set) begin
                err_restart <= 1'b1;
            end
        end
    end

    assign busy = (state == WAIT);

    sat_counter #(.W(LAT_W)) u_lat_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (lat_clr),
        .load  (lat_load),
        .inc   (lat_inc),
        .value (lat_cnt)
    );

    sat_counter #(.W(CNT_W)) u_done_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .load  (1'b0),
        .inc   (done_nx),
        .value (done_count)
    );

    sat_counter #(.W(CNT_W)) u_abort_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .load  (1'b0),
        .inc   (aborted_nx),
        .value (abort_count)
    );

endmodule
